// File: rtl/apb_periph_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_periph_pkg
// Description : Shared definitions for the MCU APB responders: register
//               offsets, timer control bit positions and the APB FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_periph_pkg;

  // Word offsets decoded from PADDR[4:2]
  localparam logic [2:0] TCR_OFS    = 3'd0;
  localparam logic [2:0] PSC_OFS    = 3'd1;
  localparam logic [2:0] ARR_OFS    = 3'd2;
  localparam logic [2:0] TCNT_OFS   = 3'd3;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  // Bit positions inside TCR and STATUS
  localparam int TCR_EN_BIT     = 0;
  localparam int TCR_CLR_BIT    = 1;
  localparam int TCR_IRQEN_BIT  = 2;
  localparam int STATUS_OVF_BIT = 0;

  // One-wait-state APB responder handshake
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

endpackage : apb_periph_pkg
`default_nettype wire

// File: rtl/timer_core.sv
`default_nettype none
// ============================================================================
// Module      : timer_core
// Description : Prescaled 32-bit up-counter with auto-reload compare and a
//               sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] psc,
  input  logic [31:0] arr,
  input  logic        ovf_clr,
  output logic [31:0] tcnt,
  output logic        ovf
);

  logic [31:0] pcnt;
  logic        tick;
  logic        wrap;

  // A tick fires on the cycle the prescaler count matches PSC; equality
  // (not >=) means a shrunk PSC/ARR lets the count run past and wrap naturally.
  assign tick = en && (pcnt == psc);
  assign wrap = tick && (tcnt == arr);

  // Prescaler and main counter; EN low simply holds both counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= 32'd0;
      tcnt <= 32'd0;
    end else if (clr) begin
      pcnt <= 32'd0;
      tcnt <= 32'd0;
    end else if (en) begin
      pcnt <= tick ? 32'd0 : pcnt + 32'd1;
      if (tick) begin
        tcnt <= wrap ? 32'd0 : tcnt + 32'd1;
      end
    end
  end

  // Sticky overflow flag; a set in the same cycle as a clear request wins.
  // A CLR overrides the count, so no overflow is recorded in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (wrap && !clr) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule : timer_core
`default_nettype wire

// File: rtl/apb_timer_periph.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_periph
// Description : APB responder wrapping a prescaled 32-bit timer with
//               auto-reload and overflow interrupt. One wait state per access.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timer_periph #(
  parameter logic [31:0] PSC_RESET = 32'd0,
  parameter logic [31:0] ARR_RESET = 32'hFFFF_FFFF
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        timer_irq
);

  import apb_periph_pkg::*;

  apb_state_e  state;
  apb_state_e  state_next;
  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  ofs;
  logic        tcr_en;
  logic        tcr_irqen;
  logic [31:0] psc;
  logic [31:0] arr;
  logic [31:0] tcnt;
  logic        ovf;
  logic        clr_pulse;
  logic        ovf_clr;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign ofs              = PADDR[4:2];
  assign unused_addr_bits = ^{PADDR[31:5], PADDR[1:0]};
  assign wr_en            = access && PWRITE;
  assign rd_en            = access && !PWRITE;

  // CLR and the STATUS W1C are strobes that act in the commit cycle only
  assign clr_pulse = wr_en && (ofs == TCR_OFS)    && PWDATA[TCR_CLR_BIT];
  assign ovf_clr   = wr_en && (ofs == STATUS_OFS) && PWDATA[STATUS_OVF_BIT];

  // APB FSM state register
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) state <= IDLE;
    else         state <= state_next;
  end

  // APB FSM next state; ACCESS completes even if PSEL/PENABLE drop
  always_comb begin
    state_next = state;
    access     = 1'b0;
    case (state)
      IDLE:    if (PSEL && PENABLE) state_next = ACCESS;
      ACCESS: begin
        access     = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Writable register file, committed in the ACCESS cycle
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      tcr_en    <= 1'b0;
      tcr_irqen <= 1'b0;
      psc       <= PSC_RESET;
      arr       <= ARR_RESET;
    end else if (wr_en) begin
      case (ofs)
        TCR_OFS: begin
          tcr_en    <= PWDATA[TCR_EN_BIT];
          tcr_irqen <= PWDATA[TCR_IRQEN_BIT];
        end
        PSC_OFS: psc <= PWDATA;
        ARR_OFS: arr <= PWDATA;
        default: ;
      endcase
    end
  end

  // Read mux; CLR and unmapped offsets read as zero
  always_comb begin
    rd_data = 32'd0;
    case (ofs)
      TCR_OFS:    rd_data = {29'd0, tcr_irqen, 1'b0, tcr_en};
      PSC_OFS:    rd_data = psc;
      ARR_OFS:    rd_data = arr;
      TCNT_OFS:   rd_data = tcnt;
      STATUS_OFS: rd_data = {31'd0, ovf};
      default:    rd_data = 32'd0;
    endcase
  end

  // Bus response: PREADY is the registered ACCESS flag, so it is high in DONE
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= 32'd0;
    end else begin
      PREADY <= access;
      if (rd_en) PRDATA <= rd_data;
    end
  end

  timer_core u_timer_core (
    .clk     (PCLK),
    .rst_n   (PRESET),
    .en      (tcr_en),
    .clr     (clr_pulse),
    .psc     (psc),
    .arr     (arr),
    .ovf_clr (ovf_clr),
    .tcnt    (tcnt),
    .ovf     (ovf)
  );

  // Both sources are flops, so the AND cannot glitch on a clock edge
  assign timer_irq = ovf & tcr_irqen;

endmodule : apb_timer_periph
`default_nettype wire

// File: tb/tb_apb_timer_periph.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_timer_periph
// Description : Scoreboard bench for apb_timer_periph.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_timer_periph;

  localparam logic [31:0] A_TCR    = 32'h00;
  localparam logic [31:0] A_PSC    = 32'h04;
  localparam logic [31:0] A_ARR    = 32'h08;
  localparam logic [31:0] A_TCNT   = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] A_RSV6   = 32'h18;

  logic        PCLK    = 1'b0;
  logic        PRESET  = 1'b0;
  logic [31:0] PADDR   = 32'd0;
  logic        PWRITE  = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL    = 1'b0;
  logic [31:0] PWDATA  = 32'd0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        timer_irq;

  apb_timer_periph #(
    .PSC_RESET (32'd0),
    .ARR_RESET (32'hFFFF_FFFF)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PENABLE   (PENABLE),
    .PSEL      (PSEL),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .timer_irq (timer_irq)
  );

  always #5 PCLK = ~PCLK;

  // Free-running edge counter used to predict timer values
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Record the cycle at which the interrupt first rises
  logic irq_seen = 1'b0;
  int   irq_cyc  = -1;
  always @(negedge PCLK) begin
    if (timer_irq && !irq_seen) begin
      irq_seen = 1'b1;
      irq_cyc  = cyc;
    end
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          commit_cyc = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Expected counter value j edges after the commit edge of a CLR/enable
  function automatic logic [31:0] tcnt_at(input int j, input int p, input int m);
    return 32'((j / p) % m);
  endfunction

  task automatic wait_cyc(input int target);
    if (cyc > target) check("sched", 32'(cyc), 32'(target));
    while (cyc < target) begin
      @(posedge PCLK); #1;
    end
  endtask

  // One APB transfer; starts and ends 1 time unit after a rising edge
  task automatic apb_xfer(input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input string tag);
    int          n;
    logic [31:0] exp;
    PSEL = 1'b1; PADDR = addr; PWRITE = wr; PWDATA = wdata; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(posedge PCLK); #1;
      n++;
    end while (!PREADY && n < 10);
    check({tag, "_lat"}, 32'(n), 32'd2);
    commit_cyc = cyc;
    if (!wr) begin
      if (exp_q.size() == 0) begin
        $display("FAIL %s: scoreboard empty", tag);
        $fatal(1);
      end
      exp = exp_q.pop_front();
      check(tag, PRDATA, exp);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check({tag, "_rdy1"}, 32'(PREADY), 32'd0);
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    apb_xfer(addr, 1'b0, 32'd0, tag);
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
    apb_xfer(addr, 1'b1, data, tag);
  endtask

  initial begin
    int c, c2, c3, k;

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", 32'(PREADY), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_irq", 32'(timer_irq), 32'd0);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    apb_read(A_TCR,    32'd0,          "rst_tcr");
    apb_read(A_PSC,    32'd0,          "rst_psc");
    apb_read(A_ARR,    32'hFFFF_FFFF,  "rst_arr");
    apb_read(A_TCNT,   32'd0,          "rst_tcnt");
    apb_read(A_STATUS, 32'd0,          "rst_status");

    // PSC=3, ARR=4, EN|IRQEN: one tick per 4 cycles, period 5 ticks
    apb_write(A_PSC, 32'd3, "wr_psc");
    apb_write(A_ARR, 32'd4, "wr_arr");
    apb_write(A_TCR, 32'd5, "wr_tcr_en");
    c = commit_cyc;
    for (int i = 0; i < 5; i++) begin
      k = cyc;
      apb_read(A_TCNT, tcnt_at(k + 2 - c, 4, 5), "cnt_seq");
    end
    for (int i = 0; i < 50 && !irq_seen; i++) begin
      @(posedge PCLK); #1;
    end
    check("irq_rise_cyc", 32'(irq_cyc - c), 32'd20);
    k = cyc;
    apb_read(A_TCNT, tcnt_at(k + 2 - c, 4, 5), "cnt_wrap");
    apb_read(A_STATUS, 32'd1, "ovf_set");
    check("irq_high", 32'(timer_irq), 32'd1);

    // W1C landing on the next overflow edge (c+40): set wins
    wait_cyc(c + 37);
    apb_write(A_STATUS, 32'd1, "w1c_collide");
    check("w1c_collide_cyc", 32'(commit_cyc - c), 32'd40);
    apb_read(A_STATUS, 32'd1, "ovf_kept");
    check("irq_kept", 32'(timer_irq), 32'd1);
    apb_write(A_STATUS, 32'd1, "w1c");
    check("irq_cleared", 32'(timer_irq), 32'd0);
    apb_read(A_STATUS, 32'd0, "ovf_cleared");

    // Pause: slower prescaler, clear, stop at TCNT=3, hold for 50 cycles
    apb_write(A_PSC, 32'd15, "wr_psc16");
    apb_write(A_TCR, 32'd3, "wr_tcr_clr");
    c2 = commit_cyc;
    apb_read(A_TCR, 32'd1, "tcr_clr_reads0");
    wait_cyc(c2 + 50);
    apb_write(A_TCR, 32'd0, "wr_tcr_off");
    repeat (50) @(posedge PCLK);
    #1;
    apb_read(A_TCNT, tcnt_at(53, 16, 5), "cnt_paused");
    apb_write(A_TCR, 32'd3, "wr_tcr_clr2");
    c3 = commit_cyc;
    k = cyc;
    apb_read(A_TCNT, tcnt_at(k + 2 - c3, 16, 5), "cnt_after_clr");
    apb_read(A_TCR, 32'd1, "tcr_after_clr");

    // Ignored writes: read-only TCNT and reserved offset 6
    apb_write(A_TCNT, 32'h55, "wr_tcnt_ro");
    apb_write(A_RSV6, 32'hFFFF, "wr_rsv6");
    k = cyc;
    apb_read(A_TCNT, tcnt_at(k + 2 - c3, 16, 5), "cnt_ro");
    apb_read(A_RSV6, 32'd0, "rsv6_zero");
    apb_read(A_ARR, 32'd4, "arr_hold");
    apb_read(A_PSC, 32'd15, "psc_hold");

    // Asynchronous reset in the ACCESS cycle of an ARR write
    PSEL = 1'b1; PADDR = A_ARR; PWRITE = 1'b1; PWDATA = 32'd7; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #2;
    PRESET = 1'b0;
    #1;
    check("arst_pready", 32'(PREADY), 32'd0);
    check("arst_prdata", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    apb_read(A_ARR,  32'hFFFF_FFFF, "arst_arr");
    apb_read(A_TCR,  32'd0,         "arst_tcr");
    apb_read(A_PSC,  32'd0,         "arst_psc");
    apb_read(A_TCNT, 32'd0,         "arst_tcnt");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_apb_timer_periph
`default_nettype wire
